pipe_ctrl_unit: RTL and testbench

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/ctrl_pkg.sv | 79 +++++++
 rtl/ctrl_decode.sv | 98 +++++++++
 rtl/pipe_ctrl_unit.sv | 100 ++++++++++
 tb/tb_pipe_ctrl_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings, control bundle and small helpers for the pipeline controller.
package ctrl_pkg;

   // RV32I major opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3, ALU_XOR = 4'd4,
      ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT  = 4'd8, ALU_SLTU = 4'd9
   } alu_op_e;

   // WB_IMM writes the U-immediate straight through (lui)
   typedef enum logic [2:0] {WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC4 = 3'd2, WB_IMM = 3'd3} wb_sel_e;
   typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_op_e;
   typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_e;

   // Operand selects: A = rs1 / PC, B = rs2 / immediate
   localparam logic SEL_A_RS1 = 1'b0, SEL_A_PC  = 1'b1;
   localparam logic SEL_B_RS2 = 1'b0, SEL_B_IMM = 1'b1;

   typedef struct packed {
      alu_op_e    alu_op;
      logic       alua_sel;
      logic       alub_sel;
      imm_op_e    imm_op;
      logic       brun;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jump;
      logic       rf_wen;
      wb_sel_e    wb_sel;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_used;
      logic       rs2_used;
      logic [2:0] funct3;
   } ctrl_t;

   // funct3 -> ALU op; alt is ins[30] (sub/sra), only R-type may select sub
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt, input logic reg_op);
      case (f3)
         3'b000:  return (alt && reg_op) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // True when instruction c actually reads architectural register r (x0 never counts)
   function automatic logic reads_reg(input ctrl_t c, input logic [4:0] r);
      return (r != 5'd0) && ((c.rs1_used && c.rs1 == r) || (c.rs2_used && c.rs2 == r));
   endfunction

   // Bypass pick for one EX source; MEM is younger so it wins, loads in MEM have no data yet
   function automatic fwd_e fwd_pick(input logic [4:0] rs, input logic mem_v, input ctrl_t mem_c,
                                     input logic wb_v, input ctrl_t wb_c);
      if (mem_v && mem_c.rf_wen && !mem_c.is_load && mem_c.rd != 5'd0 && mem_c.rd == rs)
         return FWD_MEM;
      else if (wb_v && wb_c.rf_wen && wb_c.rd != 5'd0 && wb_c.rd == rs)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I decoder producing the control bundle for one instruction.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] ins_i,
   output ctrl_t       ctrl_o
);

   logic [2:0] f3;
   logic       unused_ins;

   assign f3         = ins_i[14:12];
   assign unused_ins = ^{ins_i[31], ins_i[29:25]};

   // Per-class control; anything unrecognised stays an all-zero bubble
   always_comb begin
      ctrl_o        = '0;
      ctrl_o.funct3 = f3;
      ctrl_o.rs1    = ins_i[19:15];
      ctrl_o.rs2    = ins_i[24:20];
      case (ins_i[6:0])
         OP_R: begin
            ctrl_o.alu_op   = alu_from_f3(f3, ins_i[30], 1'b1);
            ctrl_o.brun     = (f3 == 3'b011);
            ctrl_o.rs1_used = 1'b1;
            ctrl_o.rs2_used = 1'b1;
            ctrl_o.rf_wen   = 1'b1;
            ctrl_o.rd       = ins_i[11:7];
         end
         OP_I: begin
            ctrl_o.alu_op   = alu_from_f3(f3, ins_i[30], 1'b0);
            ctrl_o.brun     = (f3 == 3'b011);
            ctrl_o.alub_sel = SEL_B_IMM;
            ctrl_o.rs1_used = 1'b1;
            ctrl_o.rf_wen   = 1'b1;
            ctrl_o.rd       = ins_i[11:7];
         end
         OP_LOAD: begin
            ctrl_o.alub_sel = SEL_B_IMM;
            ctrl_o.is_load  = 1'b1;
            ctrl_o.rs1_used = 1'b1;
            ctrl_o.rf_wen   = 1'b1;
            ctrl_o.wb_sel   = WB_MEM;
            ctrl_o.rd       = ins_i[11:7];
         end
         OP_STORE: begin
            ctrl_o.alub_sel = SEL_B_IMM;
            ctrl_o.imm_op   = IMM_S;
            ctrl_o.is_store = 1'b1;
            ctrl_o.rs1_used = 1'b1;
            ctrl_o.rs2_used = 1'b1;
         end
         OP_BRANCH: begin
            // ALU computes the target PC + imm; the comparator handles the condition
            ctrl_o.alua_sel  = SEL_A_PC;
            ctrl_o.alub_sel  = SEL_B_IMM;
            ctrl_o.imm_op    = IMM_B;
            ctrl_o.brun      = (f3[2:1] == 2'b11);
            ctrl_o.is_branch = 1'b1;
            ctrl_o.rs1_used  = 1'b1;
            ctrl_o.rs2_used  = 1'b1;
         end
         OP_JAL: begin
            ctrl_o.alua_sel = SEL_A_PC;
            ctrl_o.alub_sel = SEL_B_IMM;
            ctrl_o.imm_op   = IMM_J;
            ctrl_o.is_jump  = 1'b1;
            ctrl_o.rf_wen   = 1'b1;
            ctrl_o.wb_sel   = WB_PC4;
            ctrl_o.rd       = ins_i[11:7];
         end
         OP_JALR: begin
            ctrl_o.alub_sel = SEL_B_IMM;
            ctrl_o.is_jump  = 1'b1;
            ctrl_o.rs1_used = 1'b1;
            ctrl_o.rf_wen   = 1'b1;
            ctrl_o.wb_sel   = WB_PC4;
            ctrl_o.rd       = ins_i[11:7];
         end
         OP_LUI: begin
            ctrl_o.alub_sel = SEL_B_IMM;
            ctrl_o.imm_op   = IMM_U;
            ctrl_o.rf_wen   = 1'b1;
            ctrl_o.wb_sel   = WB_IMM;
            ctrl_o.rd       = ins_i[11:7];
         end
         OP_AUIPC: begin
            ctrl_o.alua_sel = SEL_A_PC;
            ctrl_o.alub_sel = SEL_B_IMM;
            ctrl_o.imm_op   = IMM_U;
            ctrl_o.rf_wen   = 1'b1;
            ctrl_o.rd       = ins_i[11:7];
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// 5-stage pipeline controller: decode, ID/EX/MEM/WB control registers, hazards and bypass selects.
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int unsigned FWD_EN   = 1,
   parameter int unsigned ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         id_ins,
   input  logic                id_valid,
   input  logic                ex_breq,
   input  logic                ex_brlt,
   output logic                stall,
   output logic                flush,
   output logic                pc_sel,
   output logic [ALU_OP_W-1:0] ex_alu_op,
   output logic                ex_alua_sel,
   output logic                ex_alub_sel,
   output logic                ex_brun,
   output logic [2:0]          ex_imm_op,
   output logic [1:0]          fwd_a,
   output logic [1:0]          fwd_b,
   output logic                mem_dram_wen,
   output logic                wb_rf_wen,
   output logic [2:0]          wb_sel,
   output logic [4:0]          wb_rd,
   output logic                ex_valid,
   output logic                mem_valid,
   output logic                wb_valid
);

   ctrl_t      id_c, ex_d, ex_q, mem_q, wb_q;
   logic [3:1] vld_pipe_d, vld_pipe_q;   // [1]=EX, [2]=MEM, [3]=WB
   logic       load_use, raw_any, br_taken, redirect, advance;
   logic       unused_bits;

   ctrl_decode u_dec (.ins_i(id_ins), .ctrl_o(id_c));

   // Branch condition from the EX comparator
   always_comb begin
      br_taken = 1'b0;
      case (ex_q.funct3)
         3'b000:  br_taken =  ex_breq;
         3'b001:  br_taken = !ex_breq;
         3'b100:  br_taken =  ex_brlt;
         3'b101:  br_taken = !ex_brlt;
         3'b110:  br_taken =  ex_brlt;
         3'b111:  br_taken = !ex_brlt;
         default: br_taken = 1'b0;
      endcase
   end

   // Hazard detection; a redirect kills the ID instruction anyway, so it overrides any stall
   always_comb begin
      load_use = id_valid && vld_pipe_q[1] && ex_q.is_load && reads_reg(id_c, ex_q.rd);
      raw_any  = id_valid && ((vld_pipe_q[1] && ex_q.rf_wen  && reads_reg(id_c, ex_q.rd))  ||
                              (vld_pipe_q[2] && mem_q.rf_wen && reads_reg(id_c, mem_q.rd)) ||
                              (vld_pipe_q[3] && wb_q.rf_wen  && reads_reg(id_c, wb_q.rd)));
      redirect = vld_pipe_q[1] && (ex_q.is_jump || (ex_q.is_branch && br_taken));
      stall    = !redirect && (load_use || ((FWD_EN == 0) && raw_any));
      flush    = redirect;
      pc_sel   = redirect;
      advance  = id_valid && !stall && !flush;
      ex_d     = advance ? id_c : '0;
      vld_pipe_d = {vld_pipe_q[2], vld_pipe_q[1], advance};
   end

   // Stage registers; a stall or flush drops a bubble into EX while MEM/WB keep moving
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         ex_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         ex_q       <= ex_d;
         mem_q      <= ex_q;
         wb_q       <= mem_q;
      end
   end

   assign fwd_a        = fwd_pick(ex_q.rs1, vld_pipe_q[2], mem_q, vld_pipe_q[3], wb_q);
   assign fwd_b        = fwd_pick(ex_q.rs2, vld_pipe_q[2], mem_q, vld_pipe_q[3], wb_q);
   assign ex_alu_op    = ALU_OP_W'(ex_q.alu_op);
   assign ex_alua_sel  = ex_q.alua_sel;
   assign ex_alub_sel  = ex_q.alub_sel;
   assign ex_brun      = ex_q.brun;
   assign ex_imm_op    = ex_q.imm_op;
   assign mem_dram_wen = vld_pipe_q[2] && mem_q.is_store;
   assign wb_rf_wen    = vld_pipe_q[3] && wb_q.rf_wen && (wb_q.rd != 5'd0);
   assign wb_sel       = wb_q.wb_sel;
   assign wb_rd        = wb_q.rd;
   assign ex_valid     = vld_pipe_q[1];
   assign mem_valid    = vld_pipe_q[2];
   assign wb_valid     = vld_pipe_q[3];
   assign unused_bits  = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: decode table through a stage scoreboard, then hazard/flush sequences.
module tb_pipe_ctrl_unit;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, id_valid, ex_breq, ex_brlt;
   logic [31:0] id_ins;

   // FWD_EN = 1 instance
   logic       stall, flush, pc_sel, ex_alua_sel, ex_alub_sel, ex_brun, mem_dram_wen, wb_rf_wen;
   logic       ex_valid, mem_valid, wb_valid;
   logic [3:0] ex_alu_op;
   logic [2:0] ex_imm_op, wb_sel;
   logic [1:0] fwd_a, fwd_b;
   logic [4:0] wb_rd;
   // FWD_EN = 0 instance
   logic       z_stall, z_flush, z_pc_sel, z_alua, z_alub, z_brun, z_dwen, z_rfwen;
   logic       z_exv, z_memv, z_wbv;
   logic [3:0] z_alu;
   logic [2:0] z_imm, z_wbsel;
   logic [1:0] z_fwda, z_fwdb;
   logic [4:0] z_wbrd;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          idx;
      logic [31:0] ins;
      logic [3:0]  alu;
      logic        a, b;
      logic [2:0]  imm;
      logic        brun, st, rfw;
      logic [2:0]  wbs;
      logic [4:0]  rd;
   } vec_t;

   vec_t tbl[24];
   vec_t exq[$], memq[$], wbq[$];
   vec_t mon_e;
   logic sb_on = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl_unit #(.FWD_EN(1), .ALU_OP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_ins(id_ins), .id_valid(id_valid), .ex_breq(ex_breq), .ex_brlt(ex_brlt),
      .stall(stall), .flush(flush), .pc_sel(pc_sel), .ex_alu_op(ex_alu_op), .ex_alua_sel(ex_alua_sel),
      .ex_alub_sel(ex_alub_sel), .ex_brun(ex_brun), .ex_imm_op(ex_imm_op), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_dram_wen(mem_dram_wen), .wb_rf_wen(wb_rf_wen), .wb_sel(wb_sel), .wb_rd(wb_rd),
      .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid));

   pipe_ctrl_unit #(.FWD_EN(0), .ALU_OP_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .id_ins(id_ins), .id_valid(id_valid), .ex_breq(ex_breq), .ex_brlt(ex_brlt),
      .stall(z_stall), .flush(z_flush), .pc_sel(z_pc_sel), .ex_alu_op(z_alu), .ex_alua_sel(z_alua),
      .ex_alub_sel(z_alub), .ex_brun(z_brun), .ex_imm_op(z_imm), .fwd_a(z_fwda), .fwd_b(z_fwdb),
      .mem_dram_wen(z_dwen), .wb_rf_wen(z_rfwen), .wb_sel(z_wbsel), .wb_rd(z_wbrd),
      .ex_valid(z_exv), .mem_valid(z_memv), .wb_valid(z_wbv));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins);
      id_ins   = ins;
      id_valid = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; id_valid = 1'b0; ex_breq = 1'b0; ex_brlt = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OP_R};
   endfunction
   function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] s_ins(input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
      return {7'd0, rs2, rs1, f3, 5'd0, op};
   endfunction
   function automatic logic [31:0] u_ins(input logic [4:0] rd, input logic [6:0] op);
      return {20'd0, rd, op};
   endfunction

   function automatic vec_t mk(input int idx, input logic [31:0] ins, input logic [3:0] alu, input logic a,
                               input logic b, input logic [2:0] imm, input logic brun, input logic st,
                               input logic rfw, input logic [2:0] wbs, input logic [4:0] rd);
      vec_t v;
      v.idx = idx; v.ins = ins; v.alu = alu; v.a = a; v.b = b; v.imm = imm;
      v.brun = brun; v.st = st; v.rfw = rfw; v.wbs = wbs; v.rd = rd;
      return v;
   endfunction

   // Scoreboard: each stage pops the entry the previous stage handed on
   always @(negedge clk) begin
      if (sb_on) begin
         if (wb_valid) begin
            if (wbq.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
            else begin
               mon_e = wbq.pop_front();
               chk($sformatf("wb_rf_wen[%0d]", mon_e.idx), wb_rf_wen, mon_e.rfw);
               chk($sformatf("wb_sel[%0d]", mon_e.idx), wb_sel, mon_e.wbs);
               chk($sformatf("wb_rd[%0d]", mon_e.idx), wb_rd, mon_e.rd);
            end
         end
         if (mem_valid) begin
            if (memq.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
            else begin
               mon_e = memq.pop_front();
               chk($sformatf("dram_wen[%0d]", mon_e.idx), mem_dram_wen, mon_e.st);
               wbq.push_back(mon_e);
            end
         end
         if (ex_valid) begin
            if (exq.size() == 0) chk("ex_unexpected", 32'd1, 32'd0);
            else begin
               mon_e = exq.pop_front();
               chk($sformatf("ex_alu[%0d]", mon_e.idx), ex_alu_op, mon_e.alu);
               chk($sformatf("ex_sel[%0d]", mon_e.idx), {ex_alua_sel, ex_alub_sel, ex_brun},
                   {mon_e.a, mon_e.b, mon_e.brun});
               chk($sformatf("ex_imm[%0d]", mon_e.idx), ex_imm_op, mon_e.imm);
               chk($sformatf("ex_haz[%0d]", mon_e.idx), {pc_sel, stall, fwd_a, fwd_b}, 32'd0);
               memq.push_back(mon_e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // Decode table: sources x1/x2 only, destinations never re-read, so no hazards arise
      tbl[0]  = mk(0,  r_ins(7'h00, 2, 1, 3'd0, 10), 4'd0, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 10);
      tbl[1]  = mk(1,  r_ins(7'h20, 2, 1, 3'd0, 11), 4'd1, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 11);
      tbl[2]  = mk(2,  r_ins(7'h00, 2, 1, 3'd7, 12), 4'd2, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 12);
      tbl[3]  = mk(3,  r_ins(7'h00, 2, 1, 3'd6, 13), 4'd3, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 13);
      tbl[4]  = mk(4,  r_ins(7'h00, 2, 1, 3'd4, 14), 4'd4, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 14);
      tbl[5]  = mk(5,  r_ins(7'h00, 2, 1, 3'd1, 15), 4'd5, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 15);
      tbl[6]  = mk(6,  r_ins(7'h00, 2, 1, 3'd5, 16), 4'd6, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 16);
      tbl[7]  = mk(7,  r_ins(7'h20, 2, 1, 3'd5, 17), 4'd7, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 17);
      tbl[8]  = mk(8,  r_ins(7'h00, 2, 1, 3'd2, 18), 4'd8, 0, 0, IMM_I, 0, 0, 1, WB_ALU, 18);
      tbl[9]  = mk(9,  r_ins(7'h00, 2, 1, 3'd3, 19), 4'd9, 0, 0, IMM_I, 1, 0, 1, WB_ALU, 19);
      tbl[10] = mk(10, i_ins(12'h005, 1, 3'd0, 20, OP_I), 4'd0, 0, 1, IMM_I, 0, 0, 1, WB_ALU, 20);
      tbl[11] = mk(11, i_ins(12'h005, 1, 3'd2, 21, OP_I), 4'd8, 0, 1, IMM_I, 0, 0, 1, WB_ALU, 21);
      tbl[12] = mk(12, i_ins(12'h005, 1, 3'd3, 22, OP_I), 4'd9, 0, 1, IMM_I, 1, 0, 1, WB_ALU, 22);
      tbl[13] = mk(13, i_ins(12'h405, 1, 3'd5, 23, OP_I), 4'd7, 0, 1, IMM_I, 0, 0, 1, WB_ALU, 23);
      tbl[14] = mk(14, i_ins(12'h0ff, 1, 3'd7, 24, OP_I), 4'd2, 0, 1, IMM_I, 0, 0, 1, WB_ALU, 24);
      tbl[15] = mk(15, i_ins(12'h000, 1, 3'd2, 25, OP_LOAD), 4'd0, 0, 1, IMM_I, 0, 0, 1, WB_MEM, 25);
      tbl[16] = mk(16, s_ins(2, 1, 3'd2, OP_STORE), 4'd0, 0, 1, IMM_S, 0, 1, 0, WB_ALU, 0);
      tbl[17] = mk(17, s_ins(2, 1, 3'd0, OP_BRANCH), 4'd0, 1, 1, IMM_B, 0, 0, 0, WB_ALU, 0);
      tbl[18] = mk(18, s_ins(2, 1, 3'd6, OP_BRANCH), 4'd0, 1, 1, IMM_B, 1, 0, 0, WB_ALU, 0);
      tbl[19] = mk(19, u_ins(26, OP_LUI), 4'd0, 0, 1, IMM_U, 0, 0, 1, WB_IMM, 26);
      tbl[20] = mk(20, u_ins(27, OP_AUIPC), 4'd0, 1, 1, IMM_U, 0, 0, 1, WB_ALU, 27);
      tbl[21] = mk(21, r_ins(7'h00, 2, 1, 3'd0, 0), 4'd0, 0, 0, IMM_I, 0, 0, 0, WB_ALU, 0);
      tbl[22] = mk(22, u_ins(28, 7'b1111111), 4'd0, 0, 0, IMM_I, 0, 0, 0, WB_ALU, 0);
      tbl[23] = mk(23, i_ins(12'h003, 1, 3'd1, 29, OP_I), 4'd5, 0, 1, IMM_I, 0, 0, 1, WB_ALU, 29);

      // Reset with a live add in ID: everything must read zero
      rst_n = 1'b0; ex_breq = 1'b0; ex_brlt = 1'b0;
      issue(r_ins(7'h00, 2, 1, 3'd0, 3));
      tick();
      tick();
      @(negedge clk);
      chk("rst_ctrl", {stall, flush, pc_sel, fwd_a, fwd_b, mem_dram_wen, wb_rf_wen}, 32'd0);
      chk("rst_valid", {ex_valid, mem_valid, wb_valid}, 32'd0);
      chk("rst_data", {ex_alu_op, ex_imm_op, wb_sel, wb_rd, ex_alua_sel, ex_alub_sel, ex_brun}, 32'd0);
      chk("rst_z", {z_stall, z_flush, z_pc_sel, z_fwda, z_fwdb, z_dwen, z_rfwen, z_exv, z_memv, z_wbv}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      id_valid = 1'b0;
      @(negedge clk);
      chk("first_accept", {ex_valid, mem_valid}, 32'b10);

      // Decode table through the stage scoreboard
      do_reset();
      sb_on = 1'b1;
      for (int i = 0; i < 24; i++) begin
         issue(tbl[i].ins);
         exq.push_back(tbl[i]);
         tick();
      end
      id_valid = 1'b0;
      repeat (4) tick();
      sb_on = 1'b0;
      chk("sb_drained", exq.size() + memq.size() + wbq.size(), 32'd0);

      // add x3,x1,x2 ; sub x4,x3,x1 -> MEM bypass on A, no stall
      do_reset();
      issue(r_ins(7'h00, 2, 1, 3'd0, 3));
      @(negedge clk); chk("fw_stall0", stall, 1'b0);
      tick(); issue(r_ins(7'h20, 1, 3, 3'd0, 4));
      @(negedge clk); chk("fw_stall1", stall, 1'b0);
      tick(); id_valid = 1'b0;
      @(negedge clk);
      chk("fw_sub_alu", ex_alu_op, 4'd1);
      chk("fw_sub_fwd", {ex_valid, stall, fwd_a, fwd_b}, {1'b1, 1'b0, 2'd1, 2'd0});
      tick(); @(negedge clk);
      chk("fw_add_wb", {wb_rf_wen, wb_rd}, {1'b1, 5'd3});

      // lw x5,0(x1) ; add x6,x5,x5 -> one stall, bubble, then WB bypass on both
      do_reset();
      issue(i_ins(12'h000, 1, 3'd2, 5, OP_LOAD));
      tick(); issue(r_ins(7'h00, 5, 5, 3'd0, 6));
      @(negedge clk); chk("lu_stall", stall, 1'b1);
      tick();
      @(negedge clk); chk("lu_bubble", {stall, ex_valid, mem_valid}, {1'b0, 1'b0, 1'b1});
      tick(); id_valid = 1'b0;
      @(negedge clk);
      chk("lu_fwd", {ex_valid, fwd_a, fwd_b}, {1'b1, 2'd2, 2'd2});
      chk("lu_wb", {wb_sel, wb_rd}, {WB_MEM, 5'd5});

      // Taken beq squashes the instruction behind it
      do_reset();
      ex_breq = 1'b1;
      issue(s_ins(2, 1, 3'd0, OP_BRANCH));
      @(negedge clk); chk("beq_id", pc_sel, 1'b0);
      tick(); issue(r_ins(7'h00, 2, 1, 3'd0, 7));
      @(negedge clk); chk("beq_redirect", {pc_sel, flush, stall}, 3'b110);
      tick(); id_valid = 1'b0; ex_breq = 1'b0;
      @(negedge clk); chk("beq_after", {pc_sel, flush, ex_valid}, 3'b000);
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk); chk($sformatf("beq_no_wb%0d", k), wb_rf_wen, 1'b0);
      end

      // Branch condition variants
      do_reset();
      ex_breq = 1'b1; ex_brlt = 1'b0;
      issue(s_ins(2, 1, 3'd5, OP_BRANCH));
      tick(); id_valid = 1'b0;
      @(negedge clk); chk("bge_taken", {pc_sel, ex_brun}, 2'b10);
      tick(); issue(s_ins(2, 1, 3'd7, OP_BRANCH)); ex_brlt = 1'b1;
      tick(); id_valid = 1'b0;
      @(negedge clk); chk("bgeu_not_taken", {pc_sel, flush, ex_brun}, 3'b001);
      tick(); issue(s_ins(2, 1, 3'd1, OP_BRANCH));
      tick(); id_valid = 1'b0;
      @(negedge clk); chk("bne_not_taken", pc_sel, 1'b0);
      tick(); issue(s_ins(2, 1, 3'd4, OP_BRANCH));
      tick(); id_valid = 1'b0;
      @(negedge clk); chk("blt_taken", pc_sel, 1'b1);

      // FWD_EN=0: add x3 ; add x4,x3,x3 -> three stall cycles then plain regfile read
      do_reset();
      issue(r_ins(7'h00, 2, 1, 3'd0, 3));
      @(negedge clk); chk("nf_stall0", z_stall, 1'b0);
      tick(); issue(r_ins(7'h00, 3, 3, 3'd0, 4));
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); chk($sformatf("nf_stall%0d", k), z_stall, 1'b1);
         tick();
      end
      @(negedge clk); chk("nf_release", {z_stall, z_exv}, 2'b00);
      tick(); id_valid = 1'b0;
      @(negedge clk);
      chk("nf_ex", {z_exv, z_fwda, z_fwdb, z_alu}, {1'b1, 2'd0, 2'd0, 4'd0});

      // jal x5 in EX with a RAW reader in ID: flush wins over stall, jal still writes back
      do_reset();
      issue(u_ins(5, OP_JAL));
      tick(); issue(r_ins(7'h00, 5, 5, 3'd0, 6));
      @(negedge clk);
      chk("jal_prio_z", {z_flush, z_pc_sel, z_stall}, 3'b110);
      chk("jal_redirect", {flush, pc_sel, stall}, 3'b110);
      tick(); id_valid = 1'b0;
      @(negedge clk); chk("jal_squash", {z_exv, ex_valid}, 2'b00);
      tick();
      @(negedge clk); chk("jal_wb", {wb_rf_wen, wb_sel, wb_rd}, {1'b1, WB_PC4, 5'd5});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
